// File: rtl/traffic_phase_ctrl.sv
// Multi-approach intersection controller. Approaches take turns round-robin through
// GREEN -> YELLOW -> ALL_RED. All durations are counted in timebase ticks (tick_en).
// Pedestrian button presses are latched per approach. A latched request earns a walk
// lamp at the start of that approach's next green. A request pending on any other
// approach lets the current green end early once the minimum green time has run.
module traffic_phase_ctrl #(
  parameter int unsigned NUM_PHASES      = 3,
  parameter int unsigned CNT_W           = 8,
  parameter int unsigned GREEN_TICKS     = 8,
  parameter int unsigned MIN_GREEN_TICKS = 4,
  parameter int unsigned YELLOW_TICKS    = 3,
  parameter int unsigned ALL_RED_TICKS   = 2,
  parameter int unsigned WALK_TICKS      = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick_en,
  input  logic [NUM_PHASES-1:0]         ped_req,
  output logic [1:0]                    current_state,
  output logic [$clog2(NUM_PHASES)-1:0] current_phase,
  output logic [NUM_PHASES-1:0]         red,
  output logic [NUM_PHASES-1:0]         yellow,
  output logic [NUM_PHASES-1:0]         green,
  output logic [NUM_PHASES-1:0]         walk,
  output logic [NUM_PHASES-1:0]         ped_pending
);

  localparam int unsigned PhW = $clog2(NUM_PHASES);

  typedef enum logic [1:0] {
    StGreen  = 2'b00,
    StYellow = 2'b01,
    StAllRed = 2'b10,
    StBad    = 2'b11
  } state_e;

  // Counter reload values: a state lasting DUR ticks is loaded with DUR-1.
  localparam logic [CNT_W-1:0] GreenLoad  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YellowLoad = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] AllRedLoad = CNT_W'(ALL_RED_TICKS - 1);
  // In green, the count at which the tick being taken completes MIN_GREEN_TICKS.
  localparam logic [CNT_W-1:0] EarlyCnt   = CNT_W'(GREEN_TICKS - MIN_GREEN_TICKS);
  // In green, walk is lit while count >= this value (the first WALK_TICKS ticks).
  localparam logic [CNT_W-1:0] WalkEndCnt = CNT_W'(GREEN_TICKS - WALK_TICKS);
  localparam logic [PhW-1:0]   LastPhase  = PhW'(NUM_PHASES - 1);

  // The state register is a raw vector so the unused code 2'b11 can be held and recovered.
  logic [1:0]            state_q, state_d;
  logic [PhW-1:0]        phase_q, phase_d;
  logic [PhW-1:0]        next_phase;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_PHASES-1:0] pend_q, pend_d;
  logic [NUM_PHASES-1:0] ped_prev_q;
  logic [NUM_PHASES-1:0] ped_rise;
  logic [NUM_PHASES-1:0] phase_onehot;
  logic                  walk_grant_q, walk_grant_d;
  logic                  cnt_zero;
  logic                  early_ok;
  logic                  other_pending;

  assign ped_rise   = ped_req & ~ped_prev_q;
  assign cnt_zero   = (cnt_q == '0);
  assign early_ok   = (cnt_q <= EarlyCnt);
  assign next_phase = (phase_q == LastPhase) ? '0 : phase_q + PhW'(1);

  // One-hot select of the active approach.
  always_comb begin
    phase_onehot = '0;
    phase_onehot[phase_q] = 1'b1;
  end

  assign other_pending = |(pend_q & ~phase_onehot);

  // Next-state, counter, pedestrian latch and walk-grant logic.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    cnt_d        = cnt_q;
    walk_grant_d = walk_grant_q;
    // Button edges are latched every cycle, whether or not a tick is present.
    pend_d       = pend_q | ped_rise;

    case (state_q)
      StGreen: begin
        if (tick_en) begin
          if (cnt_zero || (other_pending && early_ok)) begin
            state_d      = StYellow;
            cnt_d        = YellowLoad;
            walk_grant_d = 1'b0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      StYellow: begin
        if (tick_en) begin
          if (cnt_zero) begin
            state_d = StAllRed;
            cnt_d   = AllRedLoad;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      StAllRed: begin
        if (tick_en) begin
          if (cnt_zero) begin
            state_d      = StGreen;
            phase_d      = next_phase;
            cnt_d        = GreenLoad;
            // Only a request already latched earns the walk. An edge arriving on
            // the entry cycle is absorbed by this green and is not latched.
            walk_grant_d = pend_q[next_phase];
            pend_d[next_phase] = 1'b0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: begin
        // Unused code: fall back to a full clearance interval; the phase is kept.
        state_d = StAllRed;
        cnt_d   = AllRedLoad;
      end
    endcase
  end

  // State, counter and latch registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StAllRed;
      phase_q      <= LastPhase;
      cnt_q        <= AllRedLoad;
      pend_q       <= '0;
      ped_prev_q   <= '0;
      walk_grant_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      ped_prev_q   <= ped_req;
      walk_grant_q <= walk_grant_d;
    end
  end

  // Moore lamp decode: exactly one of red/yellow/green is lit per approach.
  always_comb begin
    green  = '0;
    yellow = '0;
    walk   = '0;
    if (state_q == StGreen) begin
      green = phase_onehot;
      if (walk_grant_q && (cnt_q >= WalkEndCnt)) begin
        walk = phase_onehot;
      end
    end
    if (state_q == StYellow) begin
      yellow = phase_onehot;
    end
    red = ~(green | yellow);
  end

  assign current_state = state_q;
  assign current_phase = phase_q;
  assign ped_pending   = pend_q;

endmodule
